multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM sequencing the yIF/yID/yEX/yDM/yWB datapath; replaces testbench-resident decode.
//  Decodes ins[31:0] per state, drives datapath controls, gates PC/IR writes, stalls on data-memory handshake.
//  Sits between the instruction register and the stage modules; the system's only PC-update authority.
// PARAMETERS
//  RESET_PC   32'h0000_0028  PC value loaded into pc_init on reset
//  HALT_INS   32'h0000_0073  instruction word that halts the sequencer (ecall)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high reset
//  run        in   1   leave IDLE and start fetching when high
//  ins        in   32  current instruction (valid from DECODE onward, held by IR)
//  zero       in   1   ALU zero flag from yEX
//  mem_ready  in   1   data memory completes access this cycle
//  pc_init    out  32  entry PC (constant RESET_PC)
//  IRWrite    out  1   latch fetched instruction
//  PCWrite    out  1   commit next PC this cycle
//  pc_sel     out  2   00 PC+4, 01 PC+branch, 10 PC+jTarget
//  RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg  out 1 each  datapath controls
//  op         out  3   ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  busy / halted / illegal  out 1 each  status flags
// BEHAVIOUR
//  Reset: state=IDLE; all control outputs 0, op=010, pc_sel=00; busy=halted=illegal=0.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR (one-hot or binary, encodings in package).
//  IDLE: run=1 -> FETCH. FETCH: IRWrite=1 -> DECODE. busy=1 in every state except IDLE/HALT/ERR.
//  DECODE: ins==HALT_INS -> HALT; unknown opcode -> ERR (illegal=1); else -> EXEC.
//  Opcodes: 0x33 R, 0x13 addi, 0x03 lw, 0x23 sw, 0x63 beq, 0x6F jal.
//  R op: f3 000&f7 00->010, f3 000&f7 20->110, 111->000, 110->001, 010->111; other f3/f7 -> ERR.
//  EXEC: ALUSrc=1 for addi/lw/sw, 0 for R/beq; beq forces op=110.
//   beq: PCWrite=1, pc_sel=01 if zero else 00 -> FETCH. lw/sw -> MEM. R/addi/jal -> WB.
//  MEM: MemRead(lw)/MemWrite(sw) held until mem_ready=1 (unbounded stall).
//   sw & mem_ready: PCWrite=1,pc_sel=00 -> FETCH. lw & mem_ready -> WB.
//  WB: RegWrite=1; Mem2Reg=1 for lw; PCWrite=1; pc_sel=10 for jal else 00 -> FETCH.
//  Latency (mem_ready immediate): beq 3, sw 4, R/addi/jal 4, lw 5 cycles FETCH-to-FETCH.
//  Controls are Moore outputs of state+ins; RegWrite/PCWrite/MemWrite never asserted in IDLE/HALT/ERR.
//  HALT, ERR: sticky until reset; run ignored. reset mid-instruction aborts; no partial PCWrite/RegWrite.
//  run dropped mid-instruction: ignored; checked only in IDLE.
//  mem_ready outside MEM: ignored.
// CONFIGURATION
//  CTRL_INSCOUNT_EN defined: extra port retired out 32; +1 on every PCWrite cycle, 0 on reset,
//   wraps 32'hFFFF_FFFF->0. Undefined: port and counter absent; all else identical.
// STRUCTURE
//  Package ctrl_pkg: state enum, opcode constants (OP_R/OP_I/OP_LW/OP_SW/OP_BEQ/OP_JAL),
//   ALU op codes, pc_sel codes.
//  Sub-module ctrl_decode: combinational ins -> {class, alu op, legal}; FSM instantiates it once.
// TESTING
//  reset, run=1, ins=add x3,x1,x2 (0x002081B3) -> FETCH..WB in 4 cycles, op=010, RegWrite=1 in WB only.
//  lw (0x0000A183), mem_ready low 3 cycles -> MemRead held 3+1 cycles, Mem2Reg=1 in WB, 8-cycle total.
//  beq with zero=1 -> pc_sel=01,PCWrite=1 in EXEC; zero=0 -> pc_sel=00; RegWrite never 1.
//  jal (0x0080006F) -> WB: RegWrite=1, pc_sel=10; sub (0x402081B3) -> op=110.
//  ins=0xFFFFFFFF -> ERR, illegal=1, no write strobes; run toggled -> stays ERR until reset.
//  ins=HALT_INS -> halted=1 after DECODE; reset asserted in MEM -> IDLE next cycle, outputs at reset values.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle controller.
//   state_e      FSM states (binary encoding)
//   ins_class_e  instruction classes produced by ctrl_decode
//   OP_*         RV32 opcode field values for the supported instructions
//   ALU_*        ALU op codes driven on op
//   PC_*         pc_sel codes
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_I   = 3'd1,
    CL_LW  = 3'd2,
    CL_SW  = 3'd3,
    CL_BEQ = 3'd4,
    CL_JAL = 3'd5
  } ins_class_e;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_BEQ = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the controller and the datapath.
//   run, ins, zero, mem_ready           datapath/system -> controller
//   pc_init, IRWrite, PCWrite, pc_sel,
//   RegWrite, ALUSrc, MemRead, MemWrite,
//   Mem2Reg, op, busy, halted, illegal  controller -> datapath/system
//   retired                             retired-instruction count, present only
//                                       when CTRL_INSCOUNT_EN is defined
// Modports: master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic        run;
  logic [31:0] ins;
  logic        zero;
  logic        mem_ready;
  logic [31:0] pc_init;
  logic        IRWrite;
  logic        PCWrite;
  logic [1:0]  pc_sel;
  logic        RegWrite;
  logic        ALUSrc;
  logic        MemRead;
  logic        MemWrite;
  logic        Mem2Reg;
  logic [2:0]  op;
  logic        busy;
  logic        halted;
  logic        illegal;
`ifdef CTRL_INSCOUNT_EN
  logic [31:0] retired;
`endif

  modport master (
    input  run, ins, zero, mem_ready,
`ifdef CTRL_INSCOUNT_EN
    output retired,
`endif
    output pc_init, IRWrite, PCWrite, pc_sel, RegWrite, ALUSrc,
    output MemRead, MemWrite, Mem2Reg, op, busy, halted, illegal
  );

  modport slave (
    output run, ins, zero, mem_ready,
`ifdef CTRL_INSCOUNT_EN
    input  retired,
`endif
    input  pc_init, IRWrite, PCWrite, pc_sel, RegWrite, ALUSrc,
    input  MemRead, MemWrite, Mem2Reg, op, busy, halted, illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction decoder.
//   opcode/funct3/funct7  in   instruction fields
//   cls                   out  instruction class
//   alu_op                out  ALU op the instruction needs in EXEC
//   legal                 out  0 for unknown opcodes and unsupported R-type functs
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ins_class_e cls,
  output logic [2:0] alu_op,
  output logic       legal
);

  always_comb begin
    cls    = CL_R;
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (opcode)
      OP_R: begin
        cls = CL_R;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'h00)      alu_op = ALU_ADD;
            else if (funct7 == 7'h20) alu_op = ALU_SUB;
            else                      legal  = 1'b0;
          end
          3'b111: begin
            alu_op = ALU_AND;
            legal  = (funct7 == 7'h00);
          end
          3'b110: begin
            alu_op = ALU_OR;
            legal  = (funct7 == 7'h00);
          end
          3'b010: begin
            alu_op = ALU_SLT;
            legal  = (funct7 == 7'h00);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_I:    cls = CL_I;
      OP_LW:   cls = CL_LW;
      OP_SW:   cls = CL_SW;
      OP_BEQ: begin
        cls    = CL_BEQ;
        alu_op = ALU_SUB;  // compare by subtraction; zero flag decides
      end
      OP_JAL:  cls = CL_JAL;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the IF/ID/EX/DM/WB datapath.
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    multicycle_ctrl_if.master: run/ins/zero/mem_ready in; pc_init,
//          IRWrite, PCWrite, pc_sel, RegWrite, ALUSrc, MemRead, MemWrite,
//          Mem2Reg, op, busy, halted, illegal out.
// Optional feature: define CTRL_INSCOUNT_EN to add bus.retired, a wrapping
// count of PCWrite cycles cleared by reset.
// Outputs are registered alongside the state; the only exceptions are the
// beq target select (needs this cycle's zero flag) and the sw PC commit
// (needs this cycle's mem_ready), which are folded in combinationally.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0028,
  parameter logic [31:0] HALT_INS = 32'h0000_0073
) (
  input logic clk,
  input logic reset,
  multicycle_ctrl_if.master bus
);

  state_e     state_reg;
  ins_class_e dec_class;
  logic [2:0] dec_op;
  logic       dec_legal;

  logic       ir_write_reg, pc_write_reg, reg_write_reg, alu_src_reg;
  logic       mem_read_reg, mem_write_reg, mem2reg_reg;
  logic       busy_reg, halted_reg, illegal_reg;
  logic       beq_exec_reg;  // in EXEC with a beq: pc_sel follows zero
  logic       sw_mem_reg;    // in MEM with a sw: PCWrite follows mem_ready
  logic [1:0] pc_sel_reg;
  logic [2:0] op_reg;
  logic       pc_write;

  ctrl_decode u_decode (
    .opcode (bus.ins[6:0]),
    .funct3 (bus.ins[14:12]),
    .funct7 (bus.ins[31:25]),
    .cls    (dec_class),
    .alu_op (dec_op),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      ir_write_reg  <= 1'b0;
      pc_write_reg  <= 1'b0;
      pc_sel_reg    <= PC_PLUS4;
      reg_write_reg <= 1'b0;
      alu_src_reg   <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      mem2reg_reg   <= 1'b0;
      op_reg        <= ALU_ADD;
      busy_reg      <= 1'b0;
      halted_reg    <= 1'b0;
      illegal_reg   <= 1'b0;
      beq_exec_reg  <= 1'b0;
      sw_mem_reg    <= 1'b0;
    end else begin
      // Every output is a pulse of the state being entered; start from idle values.
      ir_write_reg  <= 1'b0;
      pc_write_reg  <= 1'b0;
      pc_sel_reg    <= PC_PLUS4;
      reg_write_reg <= 1'b0;
      alu_src_reg   <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      mem2reg_reg   <= 1'b0;
      op_reg        <= ALU_ADD;
      busy_reg      <= 1'b0;
      halted_reg    <= 1'b0;
      illegal_reg   <= 1'b0;
      beq_exec_reg  <= 1'b0;
      sw_mem_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.run) begin
            state_reg    <= S_FETCH;
            ir_write_reg <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        S_FETCH: begin
          state_reg <= S_DECODE;
          busy_reg  <= 1'b1;
        end
        S_DECODE: begin
          if (bus.ins == HALT_INS) begin
            state_reg  <= S_HALT;
            halted_reg <= 1'b1;
          end else if (!dec_legal) begin
            state_reg   <= S_ERR;
            illegal_reg <= 1'b1;
          end else begin
            state_reg    <= S_EXEC;
            busy_reg     <= 1'b1;
            op_reg       <= dec_op;
            alu_src_reg  <= (dec_class == CL_I) || (dec_class == CL_LW) ||
                            (dec_class == CL_SW);
            pc_write_reg <= (dec_class == CL_BEQ);
            beq_exec_reg <= (dec_class == CL_BEQ);
          end
        end
        S_EXEC: begin
          busy_reg <= 1'b1;
          case (dec_class)
            CL_BEQ: begin
              state_reg    <= S_FETCH;
              ir_write_reg <= 1'b1;
            end
            CL_LW: begin
              state_reg    <= S_MEM;
              mem_read_reg <= 1'b1;
            end
            CL_SW: begin
              state_reg     <= S_MEM;
              mem_write_reg <= 1'b1;
              sw_mem_reg    <= 1'b1;
            end
            default: begin
              state_reg     <= S_WB;
              reg_write_reg <= 1'b1;
              pc_write_reg  <= 1'b1;
              pc_sel_reg    <= (dec_class == CL_JAL) ? PC_JUMP : PC_PLUS4;
            end
          endcase
        end
        S_MEM: begin
          busy_reg <= 1'b1;
          if (!bus.mem_ready) begin
            // Stall: keep the memory strobe asserted.
            mem_read_reg  <= mem_read_reg;
            mem_write_reg <= mem_write_reg;
            sw_mem_reg    <= sw_mem_reg;
          end else if (mem_read_reg) begin
            state_reg     <= S_WB;
            reg_write_reg <= 1'b1;
            mem2reg_reg   <= 1'b1;
            pc_write_reg  <= 1'b1;
          end else begin
            state_reg    <= S_FETCH;
            ir_write_reg <= 1'b1;
          end
        end
        S_WB: begin
          state_reg    <= S_FETCH;
          ir_write_reg <= 1'b1;
          busy_reg     <= 1'b1;
        end
        S_HALT: halted_reg  <= 1'b1;
        S_ERR:  illegal_reg <= 1'b1;
      endcase
    end
  end

  assign pc_write = pc_write_reg | (sw_mem_reg & bus.mem_ready);

  assign bus.pc_init  = RESET_PC;
  assign bus.IRWrite  = ir_write_reg;
  assign bus.PCWrite  = pc_write;
  assign bus.pc_sel   = (beq_exec_reg && bus.zero) ? PC_BRANCH : pc_sel_reg;
  assign bus.RegWrite = reg_write_reg;
  assign bus.ALUSrc   = alu_src_reg;
  assign bus.MemRead  = mem_read_reg;
  assign bus.MemWrite = mem_write_reg;
  assign bus.Mem2Reg  = mem2reg_reg;
  assign bus.op       = op_reg;
  assign bus.busy     = busy_reg;
  assign bus.halted   = halted_reg;
  assign bus.illegal  = illegal_reg;

`ifdef CTRL_INSCOUNT_EN
  logic [31:0] retired_reg;

  always_ff @(posedge clk) begin
    if (reset)         retired_reg <= 32'd0;
    else if (pc_write) retired_reg <= retired_reg + 32'd1;
  end

  assign bus.retired = retired_reg;
`endif

endmodule
